// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between the
// ALU writeback (port 0) and the memory-load writeback (port 1).
// Each port has a 2-entry FIFO. Heads are arbitrated round-robin into a
// registered write stage. A pending-write mask is exported for hazard checks.
// Optional build macro WBARB_STATS_EN adds the conflictCnt contention counter.
module regfile_wb_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                aluValid,
    output logic                aluReady,
    input  logic [ADDR_W-1:0]   aluDest,
    input  logic [DATA_W-1:0]   aluData,
    input  logic                memValid,
    output logic                memReady,
    input  logic [ADDR_W-1:0]   memDest,
    input  logic [DATA_W-1:0]   memData,
    output logic                wrEn,
    output logic [ADDR_W-1:0]   wrDest,
    output logic [DATA_W-1:0]   wrData,
    output logic [NUM_REGS-1:0] pendingMask,
    output logic                errFlag
`ifdef WBARB_STATS_EN
    ,
    output logic [15:0]         conflictCnt
`endif
);

    logic [ADDR_W-1:0] inDest [2];
    logic [DATA_W-1:0] inData [2];
    logic [1:0]        inValid;

    logic [ADDR_W-1:0] fifoDestQ [2][2];
    logic [DATA_W-1:0] fifoDataQ [2][2];
    logic [1:0]        headQ;
    logic [1:0]        tailQ;
    logic [1:0]        cntQ [2];

    logic [1:0]        ready;
    logic [1:0]        notEmpty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              entryValid [2][2];

    logic              rrQ;
    logic              rrD;
    logic              grantValid;
    logic              grantPort;
    logic [ADDR_W-1:0] headDest;
    logic [DATA_W-1:0] headData;

    assign inDest[0] = aluDest;
    assign inDest[1] = memDest;
    assign inData[0] = aluData;
    assign inData[1] = memData;
    assign inValid   = {memValid, aluValid};

    assign aluReady  = ready[0];
    assign memReady  = ready[1];

    // Per-port handshake and occupancy flags, derived only from registered counts
    always_comb begin
        ready    = '0;
        notEmpty = '0;
        push     = '0;
        for (int p = 0; p < 2; p++) begin
            ready[p]    = (cntQ[p] != 2'd2);
            notEmpty[p] = (cntQ[p] != 2'd0);
            push[p]     = inValid[p] && ready[p];
        end
    end

    // Round-robin pick among non-empty heads; the pointer only moves on contention
    always_comb begin
        grantValid = 1'b0;
        grantPort  = 1'b0;
        rrD        = rrQ;
        pop        = '0;
        if (notEmpty[0] && notEmpty[1]) begin
            grantValid = 1'b1;
            grantPort  = rrQ;
            rrD        = ~rrQ;
        end else if (notEmpty[0]) begin
            grantValid = 1'b1;
            grantPort  = 1'b0;
        end else if (notEmpty[1]) begin
            grantValid = 1'b1;
            grantPort  = 1'b1;
        end
        if (grantValid) begin
            pop[grantPort] = 1'b1;
        end
        headDest = fifoDestQ[grantPort][headQ[grantPort]];
        headData = fifoDataQ[grantPort][headQ[grantPort]];
    end

    // FIFO pointers and counts; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            headQ   <= '0;
            tailQ   <= '0;
            cntQ[0] <= '0;
            cntQ[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    tailQ[p] <= ~tailQ[p];
                end
                if (pop[p]) begin
                    headQ[p] <= ~headQ[p];
                end
                cntQ[p] <= cntQ[p] + {1'b0, push[p]} - {1'b0, pop[p]};
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone decides which entries are live
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                fifoDestQ[p][tailQ[p]] <= inDest[p];
                fifoDataQ[p][tailQ[p]] <= inData[p];
            end
        end
    end

    // Registered write stage; out-of-range heads are dropped and latch the sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            wrEn    <= 1'b0;
            wrDest  <= '0;
            wrData  <= '0;
            errFlag <= 1'b0;
            rrQ     <= 1'b0;
        end else begin
            wrEn <= 1'b0;
            rrQ  <= rrD;
            if (grantValid) begin
                if (int'(headDest) < NUM_REGS) begin
                    wrEn   <= 1'b1;
                    wrDest <= headDest;
                    wrData <= headData;
                end else begin
                    errFlag <= 1'b1;
                end
            end
        end
    end

    // Live-entry map, so the mask ignores stale data left in emptied slots
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int e = 0; e < 2; e++) begin
                entryValid[p][e] = (cntQ[p] == 2'd2) ||
                                   ((cntQ[p] == 2'd1) && (headQ[p] == 1'(e)));
            end
        end
    end

    // Pending mask covers queued entries plus the write currently staged
    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int p = 0; p < 2; p++) begin
                for (int e = 0; e < 2; e++) begin
                    if (entryValid[p][e] && (int'(fifoDestQ[p][e]) == i)) begin
                        pendingMask[i] = 1'b1;
                    end
                end
            end
            if (wrEn && (int'(wrDest) == i)) begin
                pendingMask[i] = 1'b1;
            end
        end
    end

`ifdef WBARB_STATS_EN
    // Saturating count of cycles where one port loses arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            conflictCnt <= '0;
        end else if (notEmpty[0] && notEmpty[1] && (conflictCnt != 16'hFFFF)) begin
            conflictCnt <= conflictCnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback producers: port 0 is ALU writeback, port 1 is memory-load writeback.
- Each port has a 2-entry FIFO with a valid/ready handshake.
- The block arbitrates between ports round-robin and drives a registered write strobe, destination and data into the register file.
- It exports a pending-write mask, which the issue/hazard logic uses to stall readers and same-destination writers.

Parameters:
ADDR_W, 4, destination register index width
DATA_W, 32, register data width
NUM_REGS, 12, number of architectural registers; legal dest range is 0..NUM_REGS-1

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
aluValid  in  1  port 0 write request
aluReady  out  1  port 0 can accept
aluDest  in  ADDR_W  port 0 destination
aluData  in  DATA_W  port 0 data
memValid  in  1  port 1 write request
memReady  out  1  port 1 can accept
memDest  in  ADDR_W  port 1 destination
memData  in  DATA_W  port 1 data
wrEn  out  1  register-file write enable
wrDest  out  ADDR_W  register-file write address
wrData  out  DATA_W  register-file write data
pendingMask  out  NUM_REGS  bit i set while any write to register i is queued or staged
errFlag  out  1  sticky: an out-of-range dest was received

Behaviour:
- Reset (synchronous, active-high): one clock with rst=1 does all of the following.
  - Empties both FIFOs.
  - Clears wrEn, wrDest and wrData to 0.
  - Sets the round-robin pointer to port 0.
  - Clears errFlag to 0.
  - Because the FIFOs empty, pendingMask reads 0 and both ready outputs read 1 from the next cycle.
  - Reset mid-operation discards all queued and staged writes; no wrEn pulse follows.
- Handshake: a push occurs on a posedge where xValid=1 and xReady=1.
  - xReady = (FIFO count < 2), derived from registered state only, never from the valid inputs.
  - dest/data are sampled only on a push. Holding valid while ready=0 is legal and loses nothing.
- FIFO: 2 entries per port, head/tail pointers wrap mod 2, count 0..2.
  - Pop and push on the same edge are allowed when count is 1; count stays 1.
  - When count is 2, ready=0, so no push occurs that cycle even if a pop occurs.
  - An entry pushed at edge T is eligible for arbitration in the cycle after T.
- Arbitration: evaluated each cycle over the non-empty FIFO heads.
  - Only one head non-empty: that head is granted.
  - Both heads non-empty: the port indicated by the round-robin pointer is granted; the pointer then moves to the other port.
  - No head non-empty: nothing is granted and the pointer holds.
  - The granted head pops at the next posedge.
- Output stage (registered), at the posedge following a grant:
  - Legal dest: wrEn=1, wrDest and wrData take the head's values.
  - Dest >= NUM_REGS: wrEn=0 and errFlag is set to 1. errFlag stays set until reset.
  - Without a grant, wrEn=0 and wrDest/wrData hold their last values.
  - Output regs update on posedge, so they are stable at the register file's negedge write.
- Latency: push at posedge T with no contention gives wrEn=1 in the cycle after posedge T+1, i.e. 2 edges.
  - Throughput: 1 write/cycle total.
  - Under continuous contention each port gets 1 write every 2 cycles.
- pendingMask: combinational from state.
  - Bit i = OR of: valid FIFO entries in either port with dest==i, and (wrEn && wrDest==i).
  - Out-of-range dests contribute nothing.
- Ordering:
  - FIFO order is preserved within a port.
  - Order across ports is not preserved. Issue logic must not launch a second write to a dest whose pendingMask bit is set.
  - The arbiter does not reorder or merge same-dest writes.

Optional Feature:
Macro: WBARB_STATS_EN
- Defined: adds output conflictCnt [15:0].
  - Increments on each cycle in which both heads are non-empty, i.e. one port loses arbitration.
  - Saturates at 16'hFFFF.
  - Clears on rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for one clock -> wrEn=0, wrDest=0, wrData=0, pendingMask=0, errFlag=0, aluReady=memReady=1.
- Single write: aluValid for one clock with dest=3, data=0xDEADBEEF -> pendingMask[3]=1 from the next cycle; 2 edges later wrEn=1, wrDest=3, wrData=0xDEADBEEF; pendingMask[3]=0 the cycle after.
- Contention: both ports push one entry on the same edge, alu dest=1/data=0x11, mem dest=2/data=0x22 -> wrEn=1 for 2 consecutive cycles, alu write (dest=1) first, then mem write (dest=2). A second simultaneous pair from that point starts with mem.
- Backpressure: push 3 consecutive alu entries while mem is also busy -> aluReady=0 after 2 pushes; third entry accepted once a slot frees; all 3 written in FIFO order, none lost.
- Illegal dest: mem pushes dest=13 -> no wrEn pulse, errFlag=1 and stays 1; a following legal write still completes normally.
- Mid-operation reset: reset with both FIFOs full -> no wrEn pulses afterward, pendingMask=0. With WBARB_STATS_EN, conflictCnt=0 after reset and equals the number of contended cycles in the contention test.
